// File: rtl/config_frame_writer.sv
// Configuration frame loader for one fabric column: sync detect, header decode,
// NumRows-word frame assembly and a registered one-hot frame strobe.
module config_frame_writer #(
  parameter int                         MaxFramesPerCol = 20,
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         NumRows         = 4,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 MODE,
  output logic                                 cfg_done,
  output logic                                 cfg_err
);

  localparam int CntW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam logic [CntW-1:0]            LastCnt = CntW'(NumRows - 1);
  localparam logic [FrameBitsPerRow-1:0] EndWord = {FrameBitsPerRow{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } state_t;

  state_t                             r_state;
  state_t                             w_next_state;
  logic [CntW-1:0]                    r_cnt;
  logic [CntW-1:0]                    w_next_cnt;
  logic [IdxW-1:0]                    r_idx;
  logic [IdxW-1:0]                    w_next_idx;
  logic                               r_mode;
  logic                               w_next_mode;
  logic                               r_err;
  logic                               w_next_err;
  logic                               r_done;
  logic                               w_next_done;
  logic                               r_s_ready;
  logic [MaxFramesPerCol-1:0]         r_strobe;
  logic [MaxFramesPerCol-1:0]         w_next_strobe;
  logic [FrameBitsPerRow*NumRows-1:0] r_frame_data;
  logic                               w_wr_en;
  logic                               w_accept;
  logic                               w_is_hdr;

  assign w_accept = s_valid && r_s_ready;
  // A header carries only a frame index in its low byte; every other bit must be zero.
  assign w_is_hdr = (s_data[FrameBitsPerRow-1:8] == {(FrameBitsPerRow-8){1'b0}}) &&
                    (s_data[7:0] < 8'(MaxFramesPerCol));

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and next-value decode for the control registers.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_idx   = r_idx;
    w_next_mode  = r_mode;
    w_next_err   = r_err;
    w_next_done  = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (s_data == SyncWord)) begin
          w_next_state = ST_HDR;
          w_next_mode  = 1'b1;
          w_next_err   = 1'b0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!w_accept) begin
          w_next_state = ST_HDR;
        end else if (s_data == EndWord) begin
          w_next_state = ST_IDLE;
          w_next_mode  = 1'b0;
          w_next_done  = 1'b1;
        end else if (s_data == SyncWord) begin
          w_next_state = ST_HDR;
        end else if (w_is_hdr) begin
          w_next_state = ST_DATA;
          w_next_idx   = s_data[IdxW-1:0];
          w_next_cnt   = {CntW{1'b0}};
        end else begin
          // Bad header: abort to IDLE but stay in configuration mode.
          w_next_state = ST_IDLE;
          w_next_err   = 1'b1;
        end
      end
      ST_DATA: begin
        if (!w_accept) begin
          w_next_state = ST_DATA;
        end else if (r_cnt == LastCnt) begin
          w_wr_en      = 1'b1;
          w_next_state = ST_STROBE;
          w_next_cnt   = {CntW{1'b0}};
        end else begin
          w_wr_en      = 1'b1;
          w_next_cnt   = r_cnt + CntW'(1);
        end
      end
      ST_STROBE: begin
        w_next_state = ST_HDR;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // One-hot strobe is computed for the cycle the FSM sits in STROBE.
  always_comb begin
    w_next_strobe = {MaxFramesPerCol{1'b0}};
    if (w_next_state == ST_STROBE) begin
      w_next_strobe[r_idx] = 1'b1;
    end else begin
      w_next_strobe = {MaxFramesPerCol{1'b0}};
    end
  end

  // Control registers and registered outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= {CntW{1'b0}};
      r_idx     <= {IdxW{1'b0}};
      r_mode    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_s_ready <= 1'b1;
      r_strobe  <= {MaxFramesPerCol{1'b0}};
    end else begin
      r_cnt     <= w_next_cnt;
      r_idx     <= w_next_idx;
      r_mode    <= w_next_mode;
      r_err     <= w_next_err;
      r_done    <= w_next_done;
      r_s_ready <= (w_next_state != ST_STROBE);
      r_strobe  <= w_next_strobe;
    end
  end

  // Frame assembly: only the slice addressed by the word counter is rewritten.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_frame_data <= {(FrameBitsPerRow*NumRows){1'b0}};
    end else begin
      for (int k = 0; k < NumRows; k++) begin
        if (w_wr_en && (r_cnt == CntW'(k))) begin
          r_frame_data[k*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
        end
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign FrameData   = r_frame_data;
  assign FrameStrobe = r_strobe;
  assign MODE        = r_mode;
  assign cfg_done    = r_done;
  assign cfg_err     = r_err;

endmodule
